uart_obs_deframer: RTL and testbench

- Consumes the raw byte stream from the UART receiver on the Arty-100T tile. The host writes sync bytes 0xCA 0xCA, then an observation vector of float32 words and a checksum byte.
- Recovers frame boundaries and assembles little-endian 32-bit words. Delivers them over a valid/ready stream to the core that feeds the MLP policy vector ALU.
- Reports frame completion, checksum result and sticky error flags. The bench monitor and tohost logic use these to judge host-to-DUT transfer health.

---
 rtl/uart_obs_deframer.sv | 142 ++++++++++++++
 tb/tb_uart_obs_deframer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_obs_deframer.sv
// rtl/uart_obs_deframer.sv - UART byte stream deframer into 32-bit observation words
// Frame layout: SYNC SYNC, NUM_WORDS little-endian words, XOR checksum byte.
module uart_obs_deframer #(
    parameter int          NUM_WORDS      = 8,
    parameter logic [7:0]  SYNC_BYTE      = 8'hCA,
    parameter int          TIMEOUT_CYCLES = 100000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_rx_valid,
    input  logic [7:0]  io_rx_bits,
    output logic        io_obs_valid,
    input  logic        io_obs_ready,
    output logic [31:0] io_obs_bits,
    output logic        io_obs_last,
    output logic        io_frame_done,
    output logic        io_frame_ok,
    output logic [15:0] io_frame_count,
    output logic        io_err_overrun,
    output logic        io_err_checksum,
    output logic        io_err_timeout,
    input  logic        io_err_clear
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, SYNC1, PAYLOAD, CHECK} state_t;

    state_t        state;
    logic [1:0]    byte_idx;
    logic [6:0]    word_idx;
    logic [7:0]    csum;
    logic [23:0]   asm_word;
    logic [TW-1:0] idle_cnt;

    logic accept;
    logic can_load;
    logic last_word;
    logic timeout_hit;
    logic overrun_evt;
    logic csum_bad_evt;

    // The output register may be refilled in the same cycle the consumer takes it.
    assign accept       = io_obs_valid && io_obs_ready;
    assign can_load     = !io_obs_valid || io_obs_ready;
    assign last_word    = (word_idx == 7'(NUM_WORDS - 1));
    assign timeout_hit  = (state != IDLE) && !io_rx_valid && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign overrun_evt  = (state == PAYLOAD) && io_rx_valid && (byte_idx == 2'd3) && !can_load;
    assign csum_bad_evt = (state == CHECK) && io_rx_valid && (io_rx_bits != csum);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state           <= IDLE;
            byte_idx        <= '0;
            word_idx        <= '0;
            csum            <= '0;
            asm_word        <= '0;
            idle_cnt        <= '0;
            io_obs_valid    <= 1'b0;
            io_obs_bits     <= '0;
            io_obs_last     <= 1'b0;
            io_frame_done   <= 1'b0;
            io_frame_ok     <= 1'b0;
            io_frame_count  <= '0;
            io_err_overrun  <= 1'b0;
            io_err_checksum <= 1'b0;
            io_err_timeout  <= 1'b0;
        end else begin
            io_frame_done <= 1'b0;
            io_frame_ok   <= 1'b0;
            if (accept) begin
                io_obs_valid <= 1'b0;
            end

            // An error event in the clearing cycle keeps its flag set.
            io_err_overrun  <= (io_err_overrun  && !io_err_clear) || overrun_evt;
            io_err_checksum <= (io_err_checksum && !io_err_clear) || csum_bad_evt;
            io_err_timeout  <= (io_err_timeout  && !io_err_clear) || timeout_hit;

            if (state == IDLE || io_rx_valid || timeout_hit) begin
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + 1'b1;
            end

            if (timeout_hit) begin
                state <= IDLE;
            end else if (io_rx_valid) begin
                case (state)
                    IDLE: begin
                        if (io_rx_bits == SYNC_BYTE) begin
                            state <= SYNC1;
                        end
                    end
                    SYNC1: begin
                        if (io_rx_bits == SYNC_BYTE) begin
                            state    <= PAYLOAD;
                            byte_idx <= '0;
                            word_idx <= '0;
                            csum     <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    PAYLOAD: begin
                        csum     <= csum ^ io_rx_bits;
                        byte_idx <= byte_idx + 2'd1;
                        case (byte_idx)
                            2'd0: asm_word[7:0]   <= io_rx_bits;
                            2'd1: asm_word[15:8]  <= io_rx_bits;
                            2'd2: asm_word[23:16] <= io_rx_bits;
                            default: begin
                                if (can_load) begin
                                    io_obs_valid <= 1'b1;
                                    io_obs_bits  <= {io_rx_bits, asm_word};
                                    io_obs_last  <= last_word;
                                    if (last_word) begin
                                        state <= CHECK;
                                    end else begin
                                        word_idx <= word_idx + 7'd1;
                                    end
                                end else begin
                                    state <= IDLE;
                                end
                            end
                        endcase
                    end
                    CHECK: begin
                        io_frame_done <= 1'b1;
                        io_frame_ok   <= (io_rx_bits == csum);
                        if (io_rx_bits == csum) begin
                            io_frame_count <= io_frame_count + 16'd1;
                        end
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_obs_deframer.sv
// tb/tb_uart_obs_deframer.sv - scoreboard bench for uart_obs_deframer
module tb_uart_obs_deframer;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_bits = 8'h00;
    logic        obs_valid;
    logic        obs_ready = 1'b1;
    logic [31:0] obs_bits;
    logic        obs_last;
    logic        frame_done;
    logic        frame_ok;
    logic [15:0] frame_count;
    logic        err_overrun;
    logic        err_checksum;
    logic        err_timeout;
    logic        err_clear = 1'b0;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [32:0] exp_words[$];
    logic        exp_ok[$];

    logic [7:0] pay [8] = '{8'h00, 8'h00, 8'h80, 8'h3F, 8'h00, 8'h00, 8'h00, 8'h40};

    uart_obs_deframer #(
        .NUM_WORDS(2),
        .SYNC_BYTE(8'hCA),
        .TIMEOUT_CYCLES(50)
    ) dut (
        .clock(clock),
        .reset(reset),
        .io_rx_valid(rx_valid),
        .io_rx_bits(rx_bits),
        .io_obs_valid(obs_valid),
        .io_obs_ready(obs_ready),
        .io_obs_bits(obs_bits),
        .io_obs_last(obs_last),
        .io_frame_done(frame_done),
        .io_frame_ok(frame_ok),
        .io_frame_count(frame_count),
        .io_err_overrun(err_overrun),
        .io_err_checksum(err_checksum),
        .io_err_timeout(err_timeout),
        .io_err_clear(err_clear)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clock) begin
        if (obs_valid && obs_ready) begin
            if (exp_words.size() == 0) begin
                chk("word_unexpected", 32'(exp_words.size()), 32'd1);
            end else begin
                logic [32:0] e;
                e = exp_words.pop_front();
                chk("word_bits", obs_bits, e[31:0]);
                chk("word_last", 32'(obs_last), 32'(e[32]));
            end
        end
        if (frame_done) begin
            if (exp_ok.size() == 0) begin
                chk("done_unexpected", 32'(exp_ok.size()), 32'd1);
            end else begin
                logic e_ok;
                e_ok = exp_ok.pop_front();
                chk("frame_ok", 32'(frame_ok), 32'(e_ok));
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_bits  = b;
        tick();
        rx_valid = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic push_frame(input logic ok);
        exp_words.push_back({1'b0, 32'h3F80_0000});
        exp_words.push_back({1'b1, 32'h4000_0000});
        exp_ok.push_back(ok);
    endtask

    task automatic send_frame(input logic [7:0] ck);
        send_byte(8'hCA);
        send_byte(8'hCA);
        for (int i = 0; i < 8; i++) send_byte(pay[i]);
        send_byte(ck);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_valid"}, 32'(obs_valid), 32'd0);
        chk({tag, "_bits"}, obs_bits, 32'd0);
        chk({tag, "_last"}, 32'(obs_last), 32'd0);
        chk({tag, "_done"}, 32'(frame_done), 32'd0);
        chk({tag, "_count"}, 32'(frame_count), 32'd0);
        chk({tag, "_errs"}, {29'd0, err_overrun, err_checksum, err_timeout}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) tick();
        do_reset();
        chk_reset_state("rst");

        // good frame, explicit latency check on the first word
        push_frame(1'b1);
        send_byte(8'hCA);
        send_byte(8'hCA);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h80);
        rx_valid = 1'b1;
        rx_bits  = 8'h3F;
        tick();
        chk("lat_valid", 32'(obs_valid), 32'd1);
        rx_valid = 1'b0;
        tick();
        for (int i = 4; i < 8; i++) send_byte(pay[i]);
        send_byte(8'hFF);
        chk("good_count", 32'(frame_count), 32'd1);
        chk("good_errs", {29'd0, err_overrun, err_checksum, err_timeout}, 32'd0);

        // bad checksum
        push_frame(1'b0);
        send_frame(8'h00);
        chk("bad_count", 32'(frame_count), 32'd1);
        chk("bad_err_csum", 32'(err_checksum), 32'd1);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        chk("clr_err_csum", 32'(err_checksum), 32'd0);

        // overrun with ready low
        do_reset();
        obs_ready = 1'b0;
        exp_words.push_back({1'b0, 32'h3F80_0000});
        send_byte(8'hCA);
        send_byte(8'hCA);
        for (int i = 0; i < 7; i++) send_byte(pay[i]);
        chk("ovr_before", 32'(err_overrun), 32'd0);
        send_byte(pay[7]);
        chk("ovr_set", 32'(err_overrun), 32'd1);
        send_byte(8'hFF);
        chk("ovr_hold_valid", 32'(obs_valid), 32'd1);
        chk("ovr_hold_bits", obs_bits, 32'h3F80_0000);
        chk("ovr_no_done", 32'(frame_count), 32'd0);
        obs_ready = 1'b1;
        tick();
        push_frame(1'b1);
        send_frame(8'hFF);
        chk("ovr_next_count", 32'(frame_count), 32'd1);

        // inter-byte timeout
        do_reset();
        send_byte(8'hCA);
        send_byte(8'hCA);
        rx_valid = 1'b1;
        rx_bits  = 8'h00;
        tick();
        rx_valid = 1'b0;
        repeat (49) tick();
        chk("to_early", 32'(err_timeout), 32'd0);
        tick();
        chk("to_set", 32'(err_timeout), 32'd1);
        push_frame(1'b1);
        send_frame(8'hFF);
        chk("to_next_count", 32'(frame_count), 32'd1);

        // resync, then third sync byte as payload
        do_reset();
        push_frame(1'b1);
        send_byte(8'hCA);
        send_byte(8'h11);
        send_frame(8'hFF);
        chk("resync_count", 32'(frame_count), 32'd1);
        exp_words.push_back({1'b0, 32'h8000_00CA});
        send_byte(8'hCA);
        send_byte(8'hCA);
        send_byte(8'hCA);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h80);

        // reset mid-frame
        do_reset();
        send_byte(8'hCA);
        send_byte(8'hCA);
        send_byte(8'h00);
        send_byte(8'h00);
        do_reset();
        chk_reset_state("midrst");
        push_frame(1'b1);
        send_frame(8'hFF);
        chk("midrst_count", 32'(frame_count), 32'd1);

        repeat (3) tick();
        chk("words_left", 32'(exp_words.size()), 32'd0);
        chk("dones_left", 32'(exp_ok.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
